// File: rtl/dmux8way16_stream_pkg.sv
// Shared constants and helpers for the 8-way stream demultiplexer.
// Provides the way count, select and occupancy widths, channel indices and a popcount.
package dmux8way16_stream_pkg;

    localparam int DMUX_WAYS  = 8;
    localparam int DMUX_SEL_W = 3;
    localparam int DMUX_OCC_W = 4;

    localparam logic [DMUX_SEL_W-1:0] CH_A = 3'd0;
    localparam logic [DMUX_SEL_W-1:0] CH_B = 3'd1;
    localparam logic [DMUX_SEL_W-1:0] CH_C = 3'd2;
    localparam logic [DMUX_SEL_W-1:0] CH_D = 3'd3;
    localparam logic [DMUX_SEL_W-1:0] CH_E = 3'd4;
    localparam logic [DMUX_SEL_W-1:0] CH_F = 3'd5;
    localparam logic [DMUX_SEL_W-1:0] CH_G = 3'd6;
    localparam logic [DMUX_SEL_W-1:0] CH_H = 3'd7;

    function automatic logic [DMUX_OCC_W-1:0] popcount8(
        input logic [DMUX_WAYS-1:0] v
    );
        logic [DMUX_OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DMUX_WAYS; i++) begin
            n = n + {{(DMUX_OCC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dmux8way16_stream_if.sv
// Bus bundle for the stream demux: one tagged input stream, eight output channels.
// slave = demux side, master = producer/consumer side (in_*, sel, bcast, out_ready, occ).
interface dmux8way16_stream_if #(
    parameter int WIDTH = 16
);
    import dmux8way16_stream_pkg::*;

    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [WIDTH-1:0]            in_data_i;
    logic [DMUX_SEL_W-1:0]       sel_i;
    logic                        bcast_i;
    logic [DMUX_WAYS-1:0]        out_valid_o;
    logic [DMUX_WAYS-1:0]        out_ready_i;
    logic [DMUX_WAYS*WIDTH-1:0]  out_data_o;
    logic [DMUX_OCC_W-1:0]       occ_o;

    modport slave (
        input  in_valid_i, in_data_i, sel_i, bcast_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, occ_o
    );

    modport master (
        output in_valid_i, in_data_i, sel_i, bcast_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, occ_o
    );

endinterface

// File: rtl/dmux8way16_stream_slot.sv
// One-entry channel slot: WIDTH data register plus valid; a load beats a same-cycle drain.
// Ports: clk_i, rst_n_i, load_i, drain_i, data_i in; valid_o, valid_nxt_o, data_o out.
module dmux8way16_stream_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             valid_nxt_o,
    output logic [WIDTH-1:0] data_o
);

    // drain_i is the consumer ready; it only empties a slot that holds a word
    assign valid_nxt_o = load_i | (valid_o & ~drain_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= valid_nxt_o;
            if (load_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/dmux8way16_stream.sv
// Registered 8-way demux: routes a tagged valid/ready stream into eight one-entry slots.
// Ports: clk_i, rst_n_i, bus (slave). Broadcast to all slots only with DMUX_BCAST_EN defined.
module dmux8way16_stream
    import dmux8way16_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    dmux8way16_stream_if.slave   bus
);

    logic                 bc;
    logic                 rdy_sel;
    logic                 rdy_all;
    logic                 acc;
    logic [DMUX_WAYS-1:0] load;
    logic [DMUX_WAYS-1:0] valid_q;
    logic [DMUX_WAYS-1:0] valid_nxt;
    logic [DMUX_OCC_W-1:0] occ_q;

`ifdef DMUX_BCAST_EN
    assign bc = bus.bcast_i;
`else
    logic unused_bcast;
    assign unused_bcast = bus.bcast_i;
    assign bc           = 1'b0;
`endif

    // drain-through: a full slot whose consumer is ready can take a new word
    assign rdy_sel = ~valid_q[bus.sel_i] | bus.out_ready_i[bus.sel_i];
    assign rdy_all = &(~valid_q | bus.out_ready_i);

    assign bus.in_ready_o = bc ? rdy_all : rdy_sel;
    assign acc            = bus.in_valid_i & bus.in_ready_o;

    always_comb begin
        load = '0;
        if (acc) begin
            if (bc) begin
                load = '1;
            end else begin
                load[bus.sel_i] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DMUX_WAYS; k++) begin : g_slot
        logic [WIDTH-1:0] d;

        dmux8way16_stream_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .load_i      (load[k]),
            .drain_i     (bus.out_ready_i[k]),
            .data_i      (bus.in_data_i),
            .valid_o     (valid_q[k]),
            .valid_nxt_o (valid_nxt[k]),
            .data_o      (d)
        );

        assign bus.out_data_o[k*WIDTH +: WIDTH] = d;
    end

    // occupancy tracks the post-edge valid vector, so it is computed from next-state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= popcount8(valid_nxt);
        end
    end

    assign bus.out_valid_o = valid_q;
    assign bus.occ_o       = occ_q;

endmodule
